vending_machine_param: RTL

//  Parametrised bottle vending controller. Accumulates credit from 5/10/25c coin pulses and vends when credit >= PRICE.

---
 rtl/vending_pkg.sv | 41 ++++
 rtl/change_dispenser.sv | 48 ++++
 rtl/vending_machine_param.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// vending_pkg: FSM state type, coin values and coin decode helpers
// shared by the vending controller and its change dispenser
package vending_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      VEND    = 2'd1,
      CHANGE  = 2'd2
   } state_t;

   localparam logic [2:0] NICKEL_V  = 3'd1;
   localparam logic [2:0] DIME_V    = 3'd2;
   localparam logic [2:0] QUARTER_V = 3'd5;

   // value of a single coin pulse; zero when none or several are high
   function automatic logic [2:0] coin_value(
      input logic n,
      input logic d,
      input logic q
   );
      logic [2:0] v;
      v = '0;
      case ({n, d, q})
         3'b100:  v = NICKEL_V;
         3'b010:  v = DIME_V;
         3'b001:  v = QUARTER_V;
         default: v = '0;
      endcase
      return v;
   endfunction

   // two or more coin pulses in the same cycle
   function automatic logic coin_multi(
      input logic n,
      input logic d,
      input logic q
   );
      return (n & d) | (n & q) | (d & q);
   endfunction

endpackage

// File: rtl/change_dispenser.sv
// change_dispenser: holds the amount still owed and pays it out
// largest coin first, one coin per step
module change_dispenser #(
   parameter int W = 4
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_step,
   output logic         o_pending,
   output logic         o_done,
   output logic         o_dime_nxt,
   output logic         o_nickel_nxt
);

   logic [W-1:0] r_rem;
   logic [W-1:0] w_rem_nxt;

   // load a new amount, or take one coin off it per step
   always_comb begin
      w_rem_nxt = r_rem;
      if (i_load) begin
         w_rem_nxt = i_load_val;
      end else if (i_step) begin
         if (r_rem >= W'(2)) begin
            w_rem_nxt = r_rem - W'(2);
         end else begin
            w_rem_nxt = '0;
         end
      end
   end

   // remaining-change register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rem <= '0;
      end else begin
         r_rem <= w_rem_nxt;
      end
   end

   assign o_pending    = (r_rem != '0);
   assign o_done       = (r_rem <= W'(2));
   assign o_dime_nxt   = (w_rem_nxt >= W'(2));
   assign o_nickel_nxt = (w_rem_nxt == W'(1));

endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: coin-credit bottle vender with serial change,
// cancel/refund and stock tracking; Moore FSM with registered outputs
module vending_machine_param
   import vending_pkg::*;
#(
   parameter int  PRICE     = 5,
   parameter int  STOCK_MAX = 15,
   localparam int CREDIT_W  = $clog2(PRICE + 5),
   localparam int STOCK_W   = $clog2(STOCK_MAX + 1)
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_nickel,
   input  logic                i_dime,
   input  logic                i_quarter,
   input  logic                i_cancel,
   input  logic                i_refill,
   output logic                o_deliver,
   output logic                o_give_nickel,
   output logic                o_give_dime,
   output logic                o_coin_reject,
   output logic                o_busy,
   output logic                o_sold_out,
   output logic [CREDIT_W-1:0] o_credit
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] w_credit_nxt;
   logic [STOCK_W-1:0]  r_stock;
   logic [STOCK_W-1:0]  w_stock_nxt;

   logic [2:0]          w_val;
   logic                w_coin;
   logic                w_multi;
   logic [CREDIT_W-1:0] w_sum;
   logic                w_reject;

   logic                w_load;
   logic [CREDIT_W-1:0] w_load_val;
   logic                w_step;
   logic                w_pending;
   logic                w_done;
   logic                w_dime_nxt;
   logic                w_nickel_nxt;

   assign w_val   = coin_value(i_nickel, i_dime, i_quarter);
   assign w_coin  = (w_val != 3'd0);
   assign w_multi = coin_multi(i_nickel, i_dime, i_quarter);
   assign w_sum   = r_credit + CREDIT_W'(w_val);

   change_dispenser #(
      .W (CREDIT_W)
   ) u_change (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_load       (w_load),
      .i_load_val   (w_load_val),
      .i_step       (w_step),
      .o_pending    (w_pending),
      .o_done       (w_done),
      .o_dime_nxt   (w_dime_nxt),
      .o_nickel_nxt (w_nickel_nxt)
   );

   // next state, credit, stock and coin acceptance
   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_stock_nxt  = r_stock;
      w_load       = 1'b0;
      w_load_val   = '0;
      w_step       = 1'b0;
      w_reject     = w_multi;
      case (r_state)
         COLLECT: begin
            if (i_cancel) begin
               w_reject = w_multi | w_coin;
               if (r_credit != '0) begin
                  w_load       = 1'b1;
                  w_load_val   = r_credit;
                  w_credit_nxt = '0;
                  w_state_nxt  = CHANGE;
               end
            end else if (w_coin) begin
               if (r_stock == '0) begin
                  w_reject = 1'b1;
               end else if (w_sum >= CREDIT_W'(PRICE)) begin
                  w_load       = 1'b1;
                  w_load_val   = w_sum - CREDIT_W'(PRICE);
                  w_credit_nxt = '0;
                  w_state_nxt  = VEND;
               end else begin
                  w_credit_nxt = w_sum;
               end
            end
         end
         VEND: begin
            w_reject    = w_multi | w_coin;
            w_stock_nxt = r_stock - STOCK_W'(1);
            w_state_nxt = w_pending ? CHANGE : COLLECT;
         end
         CHANGE: begin
            w_reject    = w_multi | w_coin;
            w_step      = 1'b1;
            w_state_nxt = w_done ? COLLECT : CHANGE;
         end
         default: begin
            w_state_nxt = COLLECT;
         end
      endcase
      if (i_refill) begin
         w_stock_nxt = STOCK_W'(STOCK_MAX);
      end
   end

   // state, credit and stock registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= COLLECT;
         r_credit <= '0;
         r_stock  <= STOCK_W'(STOCK_MAX);
      end else begin
         r_state  <= w_state_nxt;
         r_credit <= w_credit_nxt;
         r_stock  <= w_stock_nxt;
      end
   end

   // outputs registered from the state being entered
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_deliver     <= 1'b0;
         o_give_dime   <= 1'b0;
         o_give_nickel <= 1'b0;
         o_coin_reject <= 1'b0;
         o_busy        <= 1'b0;
         o_sold_out    <= 1'b0;
      end else begin
         o_deliver     <= (w_state_nxt == VEND);
         o_give_dime   <= (w_state_nxt == CHANGE) && w_dime_nxt;
         o_give_nickel <= (w_state_nxt == CHANGE) && w_nickel_nxt;
         o_coin_reject <= w_reject;
         o_busy        <= (w_state_nxt != COLLECT);
         o_sold_out    <= (w_stock_nxt == '0);
      end
   end

   assign o_credit = r_credit;

endmodule
